// File: rtl/channel_req_rr.sv
// channel_req_rr: ingress request engine for one cache input channel.
// Pops a packet header, sizes the packet in words and RAM blocks, requests
// an output port round-robin, then streams or drops the packet.
module channel_req_rr #(
  parameter int PORTNUM   = 16,
  parameter int DWIDTH    = 32,
  parameter int RAMWIDTH  = 11,
  parameter int LEN_LSB   = 7,
  parameter int LEN_MSB   = 16,
  parameter int BLK_BYTES = 64,
  parameter int HDR_BYTES = 4,
  parameter int PORT_ID   = 0,
  parameter int TIMEOUT   = 64,
  parameter int MAX_RETRY = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [DWIDTH-1:0]             i_data,
  input  logic                          i_empty,
  input  logic [PORTNUM-1:0]            i_ready,
  input  logic [PORTNUM*RAMWIDTH-1:0]   i_ramspace,
  input  logic [PORTNUM-1:0]            i_resp,
  input  logic [PORTNUM-1:0]            i_nresp,
  output logic [PORTNUM-1:0]            o_req,
  output logic                          o_rd_en,
  output logic                          o_sop,
  output logic                          o_eop,
  output logic [DWIDTH-1:0]             o_data,
  output logic                          o_data_vld,
  output logic                          o_drop
);

  localparam int LW  = LEN_MSB - LEN_LSB + 1;
  localparam int AW  = LW + 2 + $clog2(HDR_BYTES + BLK_BYTES);
  localparam int CW  = (AW > RAMWIDTH) ? AW : RAMWIDTH;
  localparam int BPW = DWIDTH / 8;
  localparam int PW  = (PORTNUM > 1) ? $clog2(PORTNUM) : 1;
  localparam int TW  = $clog2(TIMEOUT + 1);
  localparam int RW  = $clog2(MAX_RETRY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR_RD,
    S_HDR_CAP,
    S_ARB,
    S_WAIT,
    S_SEND,
    S_DROP
  } state_t;

  state_t              state, state_nxt;
  logic [DWIDTH-1:0]   hdr;
  logic [AW-1:0]       wcnt;
  logic [AW-1:0]       nblk;
  logic [AW-1:0]       pcnt;
  logic [AW-1:0]       bcnt;
  logic [PORTNUM-1:0]  excl;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       grant;
  logic [TW-1:0]       tcnt;
  logic [RW-1:0]       attempts;

  logic [AW-1:0]       len_ext;
  logic [AW-1:0]       w_in;
  logic [AW-1:0]       nblk_in;
  logic [PORTNUM-1:0]  elig;
  logic                gnt_vld;
  logic [PW-1:0]       gnt_idx;
  logic [PORTNUM-1:0]  gnt_onehot;
  logic                resp_hit;
  logic                fail_hit;
  logic [RW-1:0]       attempts_inc;
  logic                last_try;

  // Header sizing: payload words and RAM blocks, in widened arithmetic.
  always_comb begin
    len_ext = AW'(i_data[LEN_MSB:LEN_LSB]);
    w_in    = (len_ext + AW'(BPW - 1)) / AW'(BPW);
    nblk_in = (len_ext + AW'(HDR_BYTES + BLK_BYTES - 1)) / AW'(BLK_BYTES);
  end

  // Eligibility per port and first-eligible search starting at ptr.
  always_comb begin
    int unsigned idx;
    elig       = '0;
    gnt_vld    = 1'b0;
    gnt_idx    = '0;
    gnt_onehot = '0;
    idx        = 0;
    for (int unsigned p = 0; p < PORTNUM; p++) begin
      elig[p] = i_ready[p] && !excl[p] &&
                (CW'(i_ramspace[p*RAMWIDTH +: RAMWIDTH]) >= CW'(nblk));
    end
    for (int unsigned i = 0; i < PORTNUM; i++) begin
      idx = (32'(ptr) + i) % PORTNUM;
      if (!gnt_vld && elig[idx]) begin
        gnt_vld         = 1'b1;
        gnt_idx         = PW'(idx);
        gnt_onehot[idx] = 1'b1;
      end
    end
  end

  // Response decode for the granted port only; accept beats refuse and timeout.
  always_comb begin
    resp_hit     = i_resp[grant];
    fail_hit     = !i_resp[grant] && (i_nresp[grant] || (tcnt == TW'(TIMEOUT - 1)));
    attempts_inc = attempts + RW'(1);
    last_try     = (attempts_inc == RW'(MAX_RETRY));
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic. IDLE also waits out a pop still in flight, so the
  // final drain pop is not followed by a header pop from an emptied FIFO.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:    if (!i_empty && !o_rd_en) state_nxt = S_HDR_RD;
      S_HDR_RD:  state_nxt = S_HDR_CAP;
      S_HDR_CAP: state_nxt = S_ARB;
      S_ARB:     if (gnt_vld) state_nxt = S_WAIT;
      S_WAIT: begin
        if (resp_hit)      state_nxt = S_SEND;
        else if (fail_hit) state_nxt = last_try ? S_DROP : S_ARB;
      end
      S_SEND:    if (bcnt == wcnt) state_nxt = S_IDLE;
      S_DROP:    if (wcnt == '0 || pcnt == wcnt - AW'(1)) state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // Registered outputs and datapath, stepped by the current state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_req      <= '0;
      o_rd_en    <= 1'b0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_data     <= '0;
      o_data_vld <= 1'b0;
      o_drop     <= 1'b0;
      hdr        <= '0;
      wcnt       <= '0;
      nblk       <= '0;
      pcnt       <= '0;
      bcnt       <= '0;
      excl       <= '0;
      ptr        <= PW'(PORT_ID);
      grant      <= '0;
      tcnt       <= '0;
      attempts   <= '0;
    end else begin
      o_rd_en    <= 1'b0;
      o_sop      <= 1'b0;
      o_eop      <= 1'b0;
      o_data_vld <= 1'b0;
      o_drop     <= 1'b0;
      case (state)
        S_IDLE: begin
          if (state_nxt == S_HDR_RD) begin
            o_rd_en <= 1'b1;
            excl    <= '0;
          end
        end
        S_HDR_CAP: begin
          hdr      <= i_data;
          wcnt     <= w_in;
          nblk     <= nblk_in;
          attempts <= '0;
          pcnt     <= '0;
        end
        S_ARB: begin
          if (gnt_vld) begin
            grant <= gnt_idx;
            o_req <= gnt_onehot;
            tcnt  <= '0;
          end else if (excl != '0) begin
            excl <= '0;
          end
        end
        S_WAIT: begin
          if (resp_hit) begin
            o_req <= '0;
            ptr   <= (grant == PW'(PORTNUM - 1)) ? '0 : grant + PW'(1);
            bcnt  <= '0;
            if (wcnt != '0) begin
              o_rd_en <= 1'b1;
              pcnt    <= AW'(1);
            end else begin
              pcnt <= '0;
            end
          end else if (fail_hit) begin
            o_req       <= '0;
            excl[grant] <= 1'b1;
            attempts    <= attempts_inc;
            pcnt        <= '0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        S_SEND: begin
          o_data_vld <= 1'b1;
          o_sop      <= (bcnt == '0);
          o_eop      <= (bcnt == wcnt);
          o_data     <= (bcnt == '0) ? hdr : i_data;
          bcnt       <= bcnt + AW'(1);
          if (pcnt < wcnt) begin
            o_rd_en <= 1'b1;
            pcnt    <= pcnt + AW'(1);
          end
        end
        S_DROP: begin
          if (wcnt == '0) begin
            o_drop <= 1'b1;
          end else begin
            o_rd_en <= 1'b1;
            pcnt    <= pcnt + AW'(1);
            if (pcnt == wcnt - AW'(1)) o_drop <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_channel_req_rr.sv
// Bench for channel_req_rr: FIFO model, per-port responder, beat scoreboard.
module tb_channel_req_rr;

  localparam int PN = 16;
  localparam int DW = 32;
  localparam int RW = 11;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [DW-1:0]     i_data = '0;
  logic              i_empty;
  logic [PN-1:0]     i_ready = '1;
  logic [PN*RW-1:0]  i_ramspace = '0;
  logic [PN-1:0]     i_resp = '0;
  logic [PN-1:0]     i_nresp = '0;
  logic [PN-1:0]     o_req;
  logic              o_rd_en, o_sop, o_eop, o_data_vld, o_drop;
  logic [DW-1:0]     o_data;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] pkt[$];
  logic [DW-1:0] mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int sop_cyc = -1;
  int t_resp = 0;
  int drop_cnt = 0;
  logic in_pkt = 1'b0;

  channel_req_rr #(
    .PORTNUM(PN), .DWIDTH(DW), .RAMWIDTH(RW), .LEN_LSB(7), .LEN_MSB(16),
    .BLK_BYTES(64), .HDR_BYTES(4), .PORT_ID(3), .TIMEOUT(8), .MAX_RETRY(2)
  ) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_empty(i_empty),
    .i_ready(i_ready), .i_ramspace(i_ramspace), .i_resp(i_resp), .i_nresp(i_nresp),
    .o_req(o_req), .o_rd_en(o_rd_en), .o_sop(o_sop), .o_eop(o_eop),
    .o_data(o_data), .o_data_vld(o_data_vld), .o_drop(o_drop)
  );

  always #5 clk = ~clk;

  assign i_empty = (wr_ptr == rd_ptr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // FIFO model: registered read data, emptied by reset.
  always @(posedge clk) begin
    if (!rst_n) begin
      rd_ptr <= wr_ptr;
    end else if (o_rd_en) begin
      check("fifo_underflow", i_empty, 0);
      i_data <= mem[rd_ptr % 1024];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Output monitor: pops the scoreboard on every beat.
  always @(negedge clk) begin : mon
    beat_t e;
    if (!rst_n) begin
      in_pkt = 1'b0;
    end else begin
      if (o_drop) begin
        drop_cnt++;
        check("drop_with_pop", o_rd_en, 1);
      end
      if (o_data_vld) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", o_data_vld, 0);
        end else begin
          e = exp_q.pop_front();
          check("beat_data", o_data, e.d);
          check("beat_sop", o_sop, e.sop);
          check("beat_eop", o_eop, e.eop);
        end
        if (o_sop) sop_cyc = cyc;
        in_pkt = !o_eop;
      end else begin
        if (in_pkt) check("beat_gap", o_data_vld, 1);
        in_pkt = 1'b0;
        check("idle_flags", {o_sop, o_eop}, 0);
      end
    end
  end

  task automatic set_space(input int port, input int blocks);
    i_ramspace[port*RW +: RW] = RW'(blocks);
  endtask

  task automatic push_pkt(input logic [9:0] len);
    int w;
    logic [DW-1:0] h;
    w = (int'(len) + 3) / 4;
    h = {15'($urandom), len, 7'($urandom)};
    pkt.delete();
    pkt.push_back(h);
    for (int i = 0; i < w; i++) pkt.push_back($urandom);
    foreach (pkt[i]) mem[(wr_ptr + i) % 1024] = pkt[i];
    wr_ptr = wr_ptr + pkt.size();
  endtask

  task automatic expect_pkt();
    beat_t b;
    foreach (pkt[i]) begin
      b.d   = pkt[i];
      b.sop = (i == 0);
      b.eop = (i == pkt.size() - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic wait_req(input string tag, input logic [PN-1:0] exp);
    int n;
    n = 0;
    while (o_req == '0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, o_req, exp);
  endtask

  task automatic respond(input int port, input logic acc, input logic nacc);
    i_resp = '0;
    i_nresp = '0;
    i_resp[port] = acc;
    i_nresp[port] = nacc;
    t_resp = cyc;
    @(negedge clk);
    i_resp = '0;
    i_nresp = '0;
    check("req_release", o_req, 0);
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    check({tag, "_sop_lat"}, sop_cyc - t_resp, 2);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_drop(input string tag, input int d0);
    int n;
    n = 0;
    while (drop_cnt == d0 && n < 30) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check(tag, drop_cnt - d0, 1);
    check({tag, "_fifo_empty"}, i_empty, 1);
    check({tag, "_no_req"}, o_req, 0);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin : main
    int c0, n, d0;
    for (int p = 0; p < PN; p++) set_space(p, 4);
    repeat (3) @(negedge clk);
    check("rst_outputs", {o_req, o_rd_en, o_sop, o_eop, o_data_vld, o_drop}, 0);
    check("rst_data", o_data, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single accept from PORT_ID, header-to-request latency, 26-beat stream.
    c0 = cyc;
    push_pkt(10'd100);
    wait_req("t1_req", 16'h0008);
    check("t1_req_latency", cyc - c0, 4);
    @(negedge clk);
    @(negedge clk);
    check("t1_req_hold", o_req, 16'h0008);
    expect_pkt();
    respond(3, 1'b1, 1'b0);
    wait_done("t1_done");

    // Pointer advanced to 4; refusal excludes 4 and moves on to 5.
    push_pkt(10'd100);
    wait_req("t2_req", 16'h0010);
    respond(4, 1'b0, 1'b1);
    wait_req("t2_req_next", 16'h0020);
    expect_pkt();
    respond(5, 1'b1, 1'b0);
    wait_done("t2_done");

    // Space filter: port 6 has 1 block, packet needs 2.
    set_space(6, 1);
    push_pkt(10'd100);
    wait_req("t3_req", 16'h0080);
    expect_pkt();
    respond(7, 1'b1, 1'b0);
    wait_done("t3_done");
    set_space(6, 4);

    // Exact fit: LEN=60 needs 1 block and port 8 has exactly 1.
    set_space(8, 1);
    push_pkt(10'd60);
    wait_req("t4_req", 16'h0100);
    expect_pkt();
    respond(8, 1'b1, 1'b0);
    wait_done("t4_done");
    set_space(8, 4);

    // Timeout after 8 cycles, retry on port 10, refusal there exhausts retries.
    d0 = drop_cnt;
    push_pkt(10'd4);
    wait_req("t5_req", 16'h0200);
    n = 0;
    while (o_req == 16'h0200 && n < 50) begin
      n++;
      @(negedge clk);
    end
    check("t5_req_len", n, 8);
    check("t5_req_gap", o_req, 0);
    @(negedge clk);
    check("t5_retry_req", o_req, 16'h0400);
    respond(10, 1'b0, 1'b1);
    wait_drop("t5_drop", d0);

    // LEN=0, foreign resp/nresp bits ignored, resp+nresp together accepts.
    push_pkt(10'd0);
    wait_req("t6_req", 16'h0200);
    i_resp = ~16'h0200;
    i_nresp = ~16'h0200;
    @(negedge clk);
    i_resp = '0;
    i_nresp = '0;
    check("t6_ignore", o_req, 16'h0200);
    @(negedge clk);
    check("t6_ignore2", o_req, 16'h0200);
    expect_pkt();
    respond(9, 1'b1, 1'b1);
    wait_done("t6_done");

    // Two refusals drop the packet silently.
    d0 = drop_cnt;
    push_pkt(10'd8);
    wait_req("t7_req1", 16'h0400);
    respond(10, 1'b0, 1'b1);
    wait_req("t7_req2", 16'h0800);
    respond(11, 1'b0, 1'b1);
    wait_drop("t7_drop", d0);

    // Following packet is serviced normally with a fresh exclusion mask.
    push_pkt(10'd8);
    wait_req("t8_req", 16'h0400);
    expect_pkt();
    respond(10, 1'b1, 1'b0);
    wait_done("t8_done");

    // Reset in the middle of a stream.
    push_pkt(10'd100);
    wait_req("t9_req", 16'h0800);
    expect_pkt();
    respond(11, 1'b1, 1'b0);
    n = 0;
    while (sop_cyc <= t_resp && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    check("t9_streaming", o_data_vld, 1);
    #2 rst_n = 1'b0;
    #1 check("t9_rst_outputs", {o_req, o_rd_en, o_sop, o_eop, o_data_vld, o_drop}, 0);
    check("t9_rst_data", o_data, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("t9_fifo_flushed", i_empty, 1);
    @(negedge clk);
    push_pkt(10'd8);
    wait_req("t9_req_after_rst", 16'h0008);
    expect_pkt();
    respond(3, 1'b1, 1'b0);
    wait_done("t9_done");

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
